// File: rtl/update_knn10_udiv_seq.sv
// update_knn10_udiv_seq: radix-2 restoring divider, one quotient bit per enabled cycle, start/done handshake.
// Define UPDATE_KNN10_UDIV_SAT_EN to saturate dout to all ones on quotient overflow.
module update_knn10_udiv_seq #(
   parameter ID         = 32'd1,
   parameter din0_WIDTH = 32,
   parameter din1_WIDTH = 15,
   parameter dout_WIDTH = 17
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ce,
   input  logic                  start,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic                  ready,
   output logic                  done,
   output logic [dout_WIDTH-1:0] dout,
   output logic [din1_WIDTH-1:0] rem,
   output logic                  ovf,
   output logic                  div0
);
   localparam int CW = $clog2(din0_WIDTH);
   typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
   state_t state, state_nx;
   logic [CW-1:0]         cnt;
   logic [din0_WIDTH-1:0] dvd, q, q_nx;
   logic [din1_WIDTH-1:0] dvs, r, r_nx;
   logic [din1_WIDTH:0]   r_sh, r_sub;
   logic                  ge, ovf_nx;
   logic [dout_WIDTH-1:0] dout_nx;

   assign ready = state == IDLE;
   assign done  = state == FIN;

   always_comb begin
      r_sh    = {r, dvd[din0_WIDTH-1]};
      r_sub   = r_sh - {1'b0, dvs};
      ge      = r_sh >= {1'b0, dvs};
      r_nx    = ge ? r_sub[din1_WIDTH-1:0] : r_sh[din1_WIDTH-1:0];
      q_nx    = {q[din0_WIDTH-2:0], ge};
      ovf_nx  = |q_nx[din0_WIDTH-1:dout_WIDTH];
`ifdef UPDATE_KNN10_UDIV_SAT_EN
      dout_nx = ovf_nx ? {dout_WIDTH{1'b1}} : q_nx[dout_WIDTH-1:0];
`else
      dout_nx = q_nx[dout_WIDTH-1:0];
`endif
      state_nx = (state == IDLE) ? (start ? (|din1 ? CALC : FIN) : IDLE) :
                 (state == CALC) ? ((cnt == '0) ? FIN : CALC) : IDLE;
   end

   always_ff @(posedge clk)
      if (reset) state <= IDLE;
      else if (ce) state <= state_nx;

   always_ff @(posedge clk) begin
      if (reset) begin
         dvd  <= '0;
         dvs  <= '0;
         r    <= '0;
         q    <= '0;
         cnt  <= '0;
         dout <= '0;
         rem  <= '0;
         ovf  <= 1'b0;
         div0 <= 1'b0;
      end else if (ce) begin
         if (state == IDLE && start) begin
            dvd <= din0;
            dvs <= din1;
            r   <= '0;
            q   <= '0;
            cnt <= CW'(din0_WIDTH - 1);
            // divide-by-zero skips CALC, so results are loaded here for FIN
            if (din1 == '0) begin
               dout <= {dout_WIDTH{1'b1}};
               rem  <= din0[din1_WIDTH-1:0];
               ovf  <= 1'b0;
               div0 <= 1'b1;
            end
         end
         if (state == CALC) begin
            dvd <= {dvd[din0_WIDTH-2:0], 1'b0};
            r   <= r_nx;
            q   <= q_nx;
            cnt <= cnt - 1'b1;
            if (cnt == '0) begin
               dout <= dout_nx;
               rem  <= r_nx;
               ovf  <= ovf_nx;
               div0 <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_update_knn10_udiv_seq.sv
// tb_update_knn10_udiv_seq: scoreboard bench for the sequential divider.
module tb_update_knn10_udiv_seq;
   logic        clk = 0, reset = 1, ce = 1, start = 0;
   logic [31:0] din0 = 0;
   logic [14:0] din1 = 0;
   logic        ready, done, ovf, div0;
   logic [16:0] dout;
   logic [14:0] rem;
   int          cyc = 0, n_run = 0, n_fail = 0;

   typedef struct {
      logic [16:0] d;
      logic [14:0] r;
      logic        o, z;
      int          t, lat;
   } exp_t;
   exp_t sbq[$];

   update_knn10_udiv_seq dut (
      .clk(clk), .reset(reset), .ce(ce), .start(start), .din0(din0), .din1(din1),
      .ready(ready), .done(done), .dout(dout), .rem(rem), .ovf(ovf), .div0(div0)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk)
      if (done && ce && !reset) begin
         if (sbq.size() == 0) check("spurious_done", 1, 0);
         else begin
            exp_t e;
            e = sbq.pop_front();
            check("dout", dout, e.d);
            check("rem", rem, e.r);
            check("ovf", ovf, e.o);
            check("div0", div0, e.z);
            check("latency", cyc - e.t, e.lat);
         end
      end

   task automatic run(input logic [31:0] a, input logic [14:0] b, input int lat);
      exp_t e;
      logic [31:0] qq;
      int n;
      n = 0;
      while (!ready && n < 100) begin @(negedge clk); n++; end
      if (!ready) check("ready_timeout", 0, 1);
      if (b == 0) begin
         e.d = '1; e.r = a[14:0]; e.o = 0; e.z = 1;
      end else begin
         qq = a / {17'd0, b};
         e.r = 15'(a % {17'd0, b});
         e.o = (qq >> 17) != 0;
         e.z = 0;
`ifdef UPDATE_KNN10_UDIV_SAT_EN
         e.d = e.o ? 17'h1FFFF : qq[16:0];
`else
         e.d = qq[16:0];
`endif
      end
      e.t = cyc; e.lat = lat;
      sbq.push_back(e);
      din0 = a; din1 = b; start = 1;
      @(negedge clk);
      start = 0; din0 = $urandom; din1 = 15'($urandom);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 300) begin @(negedge clk); n++; end
      if (sbq.size() != 0) check("done_timeout", 0, 1);
      sbq.delete();
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_ready"}, ready, 1);
      check({tag, "_done"}, done, 0);
      check({tag, "_dout"}, dout, 0);
      check({tag, "_rem"}, rem, 0);
      check({tag, "_ovf"}, ovf, 0);
      check({tag, "_div0"}, div0, 0);
   endtask

   initial begin
      logic [31:0] a;
      logic [14:0] b;
      repeat (2) @(negedge clk);
      reset = 0;
      check_idle_zero("rst");
      run(32'd100, 15'd7, 33); wait_done();
      run(32'h1ABCD * 32'h7FFF, 15'h7FFF, 33); wait_done();
      run(32'h1234, 15'd0, 1); wait_done();
      run(32'h0002_0000, 15'd1, 33); wait_done();
      run(32'hFFFF_FFFF, 15'd1, 33); wait_done();
      run(32'd6, 15'd7, 33); wait_done();
      // stall ce mid-CALC and issue an ignored start while busy
      run(32'd100, 15'd7, 43);
      repeat (4) @(negedge clk);
      din0 = 32'd999; din1 = 15'd3; start = 1;
      @(negedge clk);
      start = 0; ce = 0;
      repeat (10) @(negedge clk);
      ce = 1;
      wait_done();
      repeat (5) @(negedge clk);
      // reset mid-division abandons it
      run(32'hDEAD_BEEF, 15'd123, 33);
      repeat (4) @(negedge clk);
      reset = 1;
      @(negedge clk);
      reset = 0;
      sbq.delete();
      check_idle_zero("midrst");
      repeat (40) @(negedge clk);
      run(32'd100, 15'd7, 33); wait_done();
      for (int i = 0; i < 12; i++) begin
         a = $urandom;
         b = (i % 4 == 0) ? 15'($urandom_range(1, 3)) : (i == 5) ? 15'd0 : 15'($urandom);
         run(a, b, (b == 0) ? 1 : 33);
         wait_done();
      end
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
